// File: rtl/martian_date_counter.sv
// Martian calendar date counter: year/month/day advanced by sol_tick, with a validated load.
// Latency: one cycle from sol_tick/load to updated date and registered pulses.
// Backpressure: none; a load always takes priority over a same-cycle sol_tick.
module martian_date_counter #(
    parameter int NUM_MONTHS = 24,
    parameter int YEAR_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sol_tick,
    input  logic              load,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [4:0]        load_month,
    input  logic [4:0]        load_day,
    output logic [YEAR_W-1:0] year,
    output logic [4:0]        month,
    output logic [4:0]        day,
    output logic              leap,
    output logic              D27,
    output logic              D28,
    output logic              month_rollover,
    output logic              year_rollover,
    output logic              load_err
);

    localparam logic [4:0] LAST_MONTH = 5'(NUM_MONTHS - 1);

    // Even months have 28 days; odd have 27, except the final month of a leap year.
    function automatic logic [4:0] month_len(input logic [4:0] m, input logic lp);
        if (!m[0])
            return 5'd28;
        else if (m == LAST_MONTH && lp)
            return 5'd28;
        else
            return 5'd27;
    endfunction

    logic [3:0] decade;
    logic [4:0] cur_len;
    logic       end_of_month;
    logic       end_of_year;

    logic [3:0] ld_decade;
    logic       ld_leap;
    logic [4:0] ld_len;
    logic       ld_ok;

    assign leap         = year[0] | (decade == 4'd0);
    assign cur_len      = month_len(month, leap);
    assign D28          = (cur_len == 5'd28);
    assign D27          = ~D28;
    assign end_of_month = (day == cur_len);
    assign end_of_year  = end_of_month && (month == LAST_MONTH);

    assign ld_decade = 4'(load_year % YEAR_W'(10));
    assign ld_leap   = load_year[0] | (ld_decade == 4'd0);
    assign ld_len    = month_len(load_month, ld_leap);
    assign ld_ok     = ({1'b0, load_month} < 6'(NUM_MONTHS))
                     && (load_day != 5'd0) && (load_day <= ld_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year           <= '0;
            month          <= 5'd0;
            day            <= 5'd1;
            decade         <= 4'd0;
            month_rollover <= 1'b0;
            year_rollover  <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            month_rollover <= 1'b0;
            year_rollover  <= 1'b0;
            load_err       <= 1'b0;
            if (load) begin
                // A rejected load still swallows any same-cycle tick.
                if (ld_ok) begin
                    year   <= load_year;
                    month  <= load_month;
                    day    <= load_day;
                    decade <= ld_decade;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (sol_tick) begin
                if (!end_of_month) begin
                    day <= day + 5'd1;
                end else begin
                    day            <= 5'd1;
                    month_rollover <= 1'b1;
                    if (end_of_year) begin
                        month         <= 5'd0;
                        year_rollover <= 1'b1;
                        year          <= year + 1'b1;
                        if (year == {YEAR_W{1'b1}})
                            decade <= 4'd0;
                        else if (decade == 4'd9)
                            decade <= 4'd0;
                        else
                            decade <= decade + 4'd1;
                    end else begin
                        month <= month + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_martian_date_counter.sv
// Directed bench: vector table on the default 24-month instance, plus hand sequences for reset and a 4-month year.
module tb_martian_date_counter;

    logic        clk;
    logic        rst_n;
    logic        sol_tick, load;
    logic [11:0] load_year;
    logic [4:0]  load_month, load_day;
    logic [11:0] year;
    logic [4:0]  month, day;
    logic        leap, D27, D28, month_rollover, year_rollover, load_err;

    logic        sol_tick4, load4;
    logic [11:0] load_year4;
    logic [4:0]  load_month4, load_day4;
    logic [11:0] year4;
    logic [4:0]  month4, day4;
    logic        leap4, d27_4, d28_4, mro4, yro4, lerr4;

    int checks = 0;
    int failures = 0;

    martian_date_counter #(.NUM_MONTHS(24), .YEAR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .sol_tick(sol_tick), .load(load),
        .load_year(load_year), .load_month(load_month), .load_day(load_day),
        .year(year), .month(month), .day(day), .leap(leap), .D27(D27), .D28(D28),
        .month_rollover(month_rollover), .year_rollover(year_rollover), .load_err(load_err)
    );

    martian_date_counter #(.NUM_MONTHS(4), .YEAR_W(12)) dut4 (
        .clk(clk), .rst_n(rst_n), .sol_tick(sol_tick4), .load(load4),
        .load_year(load_year4), .load_month(load_month4), .load_day(load_day4),
        .year(year4), .month(month4), .day(day4), .leap(leap4), .D27(d27_4), .D28(d28_4),
        .month_rollover(mro4), .year_rollover(yro4), .load_err(lerr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        tk;
        logic [11:0] ly;
        logic [4:0]  lm;
        logic [4:0]  ldy;
        logic [11:0] e_year;
        logic [4:0]  e_month;
        logic [4:0]  e_day;
        logic        e_leap;
        logic        e_d28;
        logic        e_mro;
        logic        e_yro;
        logic        e_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int y, input int m, input int d,
                            input int lp, input int d28);
        chk({tag, ".year"}, int'(year), y);
        chk({tag, ".month"}, int'(month), m);
        chk({tag, ".day"}, int'(day), d);
        chk({tag, ".leap"}, int'(leap), lp);
        chk({tag, ".D28"}, int'(D28), d28);
        chk({tag, ".D27"}, int'(D27), 1 - d28);
    endtask

    task automatic chk_pulses(input string tag, input int mro, input int yro, input int err);
        chk({tag, ".month_rollover"}, int'(month_rollover), mro);
        chk({tag, ".year_rollover"}, int'(year_rollover), yro);
        chk({tag, ".load_err"}, int'(load_err), err);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sol_tick  = 1'b0;
        load      = 1'b0;
        sol_tick4 = 1'b0;
        load4     = 1'b0;
    endtask

    function automatic vec_t mk(input logic ld, input logic tk, input int ly, input int lm,
                                input int ldy, input int ey, input int em, input int ed,
                                input logic el, input logic e28, input logic emr,
                                input logic eyr, input logic eer);
        vec_t v;
        v.ld = ld; v.tk = tk; v.ly = 12'(ly); v.lm = 5'(lm); v.ldy = 5'(ldy);
        v.e_year = 12'(ey); v.e_month = 5'(em); v.e_day = 5'(ed);
        v.e_leap = el; v.e_d28 = e28; v.e_mro = emr; v.e_yro = eyr; v.e_err = eer;
        return v;
    endfunction

    initial begin
        int mro_count;

        //            ld tk  ly    lm  ld   year  mo  day leap d28 mro yro err
        vecs[0]  = mk(1, 0, 3,    23, 28,  3,    23, 28, 1,   1,  0,  0,  0);
        vecs[1]  = mk(0, 1, 0,    0,  0,   4,    0,  1,  0,   1,  1,  1,  0);
        vecs[2]  = mk(0, 0, 0,    0,  0,   4,    0,  1,  0,   1,  0,  0,  0);
        vecs[3]  = mk(1, 0, 4,    23, 28,  4,    0,  1,  0,   1,  0,  0,  1);
        vecs[4]  = mk(1, 0, 20,   23, 28,  20,   23, 28, 1,   1,  0,  0,  0);
        vecs[5]  = mk(1, 1, 4,    23, 27,  4,    23, 27, 0,   0,  0,  0,  0);
        vecs[6]  = mk(0, 1, 0,    0,  0,   5,    0,  1,  1,   1,  1,  1,  0);
        vecs[7]  = mk(1, 0, 5,    1,  0,   5,    0,  1,  1,   1,  0,  0,  1);
        vecs[8]  = mk(1, 0, 4095, 23, 28,  4095, 23, 28, 1,   1,  0,  0,  0);
        vecs[9]  = mk(0, 1, 0,    0,  0,   0,    0,  1,  1,   1,  1,  1,  0);
        vecs[10] = mk(1, 1, 7,    3,  4,   7,    3,  4,  1,   0,  0,  0,  0);
        vecs[11] = mk(1, 1, 7,    24, 5,   7,    3,  4,  1,   0,  0,  0,  1);
        vecs[12] = mk(0, 1, 0,    0,  0,   7,    3,  5,  1,   0,  0,  0,  0);
        vecs[13] = mk(1, 0, 9,    5,  28,  7,    3,  5,  1,   0,  0,  0,  1);
        vecs[14] = mk(1, 0, 19,   22, 28,  19,   22, 28, 1,   1,  0,  0,  0);
        vecs[15] = mk(0, 1, 0,    0,  0,   19,   23, 1,  1,   1,  1,  0,  0);
        vecs[16] = mk(1, 0, 9,    23, 28,  9,    23, 28, 1,   1,  0,  0,  0);
        vecs[17] = mk(0, 1, 0,    0,  0,   10,   0,  1,  1,   1,  1,  1,  0);

        rst_n = 1'b0;
        sol_tick = 0; load = 0; load_year = 0; load_month = 0; load_day = 0;
        sol_tick4 = 0; load4 = 0; load_year4 = 0; load_month4 = 0; load_day4 = 0;
        #12;
        chk_date("reset", 0, 0, 1, 1, 1);
        chk_pulses("reset", 0, 0, 0);
        rst_n = 1'b1;
        step();

        // 28 sols from reset finish month 0.
        mro_count = 0;
        for (int i = 1; i <= 28; i++) begin
            sol_tick = 1'b1;
            step();
            if (month_rollover) mro_count++;
            if (i == 27) begin
                chk_date("tick27", 0, 0, 28, 1, 1);
                chk_pulses("tick27", 0, 0, 0);
            end
        end
        chk_date("tick28", 0, 1, 1, 1, 0);
        chk_pulses("tick28", 1, 0, 0);
        chk("tick28.mro_count", mro_count, 1);
        step();
        chk_pulses("tick28_idle", 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            load       = vecs[i].ld;
            sol_tick   = vecs[i].tk;
            load_year  = vecs[i].ly;
            load_month = vecs[i].lm;
            load_day   = vecs[i].ldy;
            step();
            chk_date($sformatf("vec%0d", i), int'(vecs[i].e_year), int'(vecs[i].e_month),
                     int'(vecs[i].e_day), int'(vecs[i].e_leap), int'(vecs[i].e_d28));
            chk_pulses($sformatf("vec%0d", i), int'(vecs[i].e_mro), int'(vecs[i].e_yro),
                       int'(vecs[i].e_err));
        end

        // Mid-cycle reset with a load and tick pending clears state without a clock edge.
        load = 1'b1; sol_tick = 1'b1;
        load_year = 12'd33; load_month = 5'd2; load_day = 5'd9;
        #2;
        rst_n = 1'b0;
        #1;
        chk_date("async_rst", 0, 0, 1, 1, 1);
        chk_pulses("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        chk_date("rst_held", 0, 0, 1, 1, 1);
        load = 1'b0; sol_tick = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk_date("post_rst_idle", 0, 0, 1, 1, 1);
        chk_pulses("post_rst_idle", 0, 0, 0);

        // Four-month year: 28+27+28+27 = 110 sols from year 2.
        load4 = 1'b1; load_year4 = 12'd2; load_month4 = 5'd0; load_day4 = 5'd1;
        step();
        chk("nm4.load_year", int'(year4), 2);
        chk("nm4.load_leap", int'(leap4), 0);
        for (int i = 1; i <= 110; i++) begin
            sol_tick4 = 1'b1;
            step();
            if (i == 109) begin
                chk("nm4.t109.month", int'(month4), 3);
                chk("nm4.t109.day", int'(day4), 27);
                chk("nm4.t109.D27", int'(d27_4), 1);
            end
        end
        chk("nm4.year", int'(year4), 3);
        chk("nm4.month", int'(month4), 0);
        chk("nm4.day", int'(day4), 1);
        chk("nm4.year_rollover", int'(yro4), 1);
        chk("nm4.month_rollover", int'(mro4), 1);
        chk("nm4.load_err", int'(lerr4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
